// File: rtl/uart_rx_fifo.sv
// Receive-side frame FIFO behind the UART receiver: edge-detected frame capture,
// registered 1-cycle read port, sticky overflow flag and saturating error-frame counter.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter bit DROP_ERR = 1'b0,
    parameter int ERRCNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               p_data,
    input  logic                     valid_data,
    input  logic                     parity_err,
    input  logic                     stop_err,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_perr,
    output logic                     rd_serr,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [ERRCNT_W-1:0]      err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [9:0]          mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_perr_q, rd_perr_d;
    logic                rd_serr_q, rd_serr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                valq_q, valq_d;

    logic wr_evt_s, err_s, accept_s, rd_fire_s, do_wr_s, empty_s, full_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == CW'(DEPTH));

    // Handshake decode: one write event per rising edge of valid_data.
    always_comb begin
        wr_evt_s  = valid_data & ~valq_q;
        err_s     = parity_err | stop_err;
        accept_s  = wr_evt_s & ~(DROP_ERR & err_s);
        rd_fire_s = rd_en & ~empty_s;
        do_wr_s   = accept_s & (~full_s | rd_fire_s);
    end

    // Next-state for pointers, occupancy, read port and statistics.
    always_comb begin
        valq_d     = valid_data;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_perr_d  = rd_perr_q;
        rd_serr_d  = rd_serr_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_fire_s) begin
            rd_ptr_d   = rd_ptr_q + AW'(1'b1);
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q][7:0];
            rd_perr_d  = mem_q[rd_ptr_q][8];
            rd_serr_d  = mem_q[rd_ptr_q][9];
        end else begin
            rd_valid_d = 1'b0;
        end

        case ({do_wr_s, rd_fire_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        // A new loss outranks a simultaneous clear so no event goes unreported.
        if (accept_s & full_s & ~rd_fire_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (wr_evt_s && err_s && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1'b1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Control and output registers; valq resets high to ignore a level held through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valq_q     <= 1'b1;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            rd_data_q  <= 8'h00;
            rd_perr_q  <= 1'b0;
            rd_serr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= {ERRCNT_W{1'b0}};
        end else begin
            valq_q     <= valq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_perr_q  <= rd_perr_d;
            rd_serr_q  <= rd_serr_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Frame storage; contents become unreachable on reset via the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= {stop_err, parity_err, p_data};
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_perr  = rd_perr_q;
    assign rd_serr  = rd_serr_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_s;
    assign full     = full_s;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;

endmodule
